// File: rtl/tc_accumulator_bank_if.sv
// Timer/counter bank bus: presets, rung conditions, channel commands and done/readback outputs.
// The master side drives commands and presets. The slave side (the bank) returns done bits and the accumulator readback.
interface tc_accumulator_bank_if #(
    parameter int TC_NUM     = 16,
    parameter int PRESET_LEN = 8,
    parameter int ADDR_LEN   = 4
);
    logic [TC_NUM*PRESET_LEN-1:0] presetIn;
    logic [TC_NUM-1:0]            tcEn;
    logic [ADDR_LEN-1:0]          tcAddr;
    logic                         tcRstEn;
    logic                         tcTypeWr;
    logic [1:0]                   tcTypeIn;
    logic [ADDR_LEN-1:0]          tcRdAddr;
    logic [TC_NUM-1:0]            tcDone;
    logic [PRESET_LEN-1:0]        accOut;

    modport master (
        output presetIn, tcEn, tcAddr, tcRstEn, tcTypeWr, tcTypeIn, tcRdAddr,
        input  tcDone, accOut
    );

    modport slave (
        input  presetIn, tcEn, tcAddr, tcRstEn, tcTypeWr, tcTypeIn, tcRdAddr,
        output tcDone, accOut
    );
endinterface

// File: rtl/tc_accumulator_bank.sv
// Timer/counter execution bank: one accumulator, done bit and type per channel (TON/TOF/CTU/RTO).
// Optional feature macro TC_ACC_READ_EN enables the registered accumulator readback on accOut.
module tc_accumulator_bank #(
    parameter int TC_NUM     = 16,
    parameter int PRESET_LEN = 8,
    parameter int ADDR_LEN   = 4,
    parameter int TICK_DIV   = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    tc_accumulator_bank_if.slave   tc_bus
);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        TC_TON = 2'b00,
        TC_TOF = 2'b01,
        TC_CTU = 2'b10,
        TC_RTO = 2'b11
    } tc_type_e;

    logic [PS_W-1:0] prescale_q;
    logic            tick;
    logic            cmd_any;
    logic [TC_NUM-1:0] done_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
        end else if (prescale_q == PS_LAST) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + PS_W'(1);
        end
    end

    assign tick    = (prescale_q == PS_LAST);
    assign cmd_any = tc_bus.tcRstEn | tc_bus.tcTypeWr;

`ifdef TC_ACC_READ_EN
    logic [PRESET_LEN-1:0] acc_w [TC_NUM];
`endif

    generate
        for (genvar gi = 0; gi < TC_NUM; gi++) begin : g_chan
            logic [PRESET_LEN-1:0] acc_q;
            logic [PRESET_LEN-1:0] acc_d;
            logic [PRESET_LEN-1:0] preset;
            logic [PRESET_LEN-1:0] acc_inc;
            logic                  done_q;
            logic                  done_d;
            logic                  en_prev_q;
            logic                  en;
            logic                  rise;
            logic                  hit;
            logic                  under;
            tc_type_e              type_q;
            tc_type_e              type_d;

            assign preset  = tc_bus.presetIn[gi*PRESET_LEN +: PRESET_LEN];
            assign en      = tc_bus.tcEn[gi];
            assign rise    = en & ~en_prev_q;
            assign hit     = cmd_any && (tc_bus.tcAddr == ADDR_LEN'(gi));
            assign under   = (acc_q < preset);
            assign acc_inc = acc_q + PRESET_LEN'(1);

            // Done is judged against the post-edge accumulator so it settles on the same edge.
            always_comb begin
                acc_d  = acc_q;
                done_d = 1'b0;
                type_d = type_q;
                if (hit) begin
                    acc_d = '0;
                    if (tc_bus.tcTypeWr) begin
                        type_d = tc_type_e'(tc_bus.tcTypeIn);
                    end
                end else begin
                    case (type_q)
                        TC_TON: begin
                            if (!en) begin
                                acc_d = '0;
                            end else if (tick && under) begin
                                acc_d = acc_inc;
                            end
                            done_d = en && (acc_d >= preset);
                        end
                        TC_TOF: begin
                            if (en) begin
                                acc_d = '0;
                            end else if (tick && under) begin
                                acc_d = acc_inc;
                            end
                            done_d = en || (acc_d < preset);
                        end
                        TC_CTU: begin
                            if (rise && (acc_q != '1)) begin
                                acc_d = acc_inc;
                            end
                            done_d = (acc_d >= preset);
                        end
                        default: begin
                            if (en && tick && under) begin
                                acc_d = acc_inc;
                            end
                            done_d = (acc_d >= preset);
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc_q     <= '0;
                    done_q    <= 1'b0;
                    en_prev_q <= 1'b0;
                    type_q    <= TC_TON;
                end else begin
                    acc_q     <= acc_d;
                    done_q    <= done_d;
                    en_prev_q <= en;
                    type_q    <= type_d;
                end
            end

            assign done_w[gi] = done_q;
`ifdef TC_ACC_READ_EN
            assign acc_w[gi] = acc_q;
`endif
        end
    endgenerate

    assign tc_bus.tcDone = done_w;

`ifdef TC_ACC_READ_EN
    logic [PRESET_LEN-1:0] acc_out_q;

    // Unpopulated addresses read back as zero rather than aliasing a real channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_out_q <= '0;
        end else if (int'(tc_bus.tcRdAddr) < TC_NUM) begin
            acc_out_q <= acc_w[tc_bus.tcRdAddr];
        end else begin
            acc_out_q <= '0;
        end
    end

    assign tc_bus.accOut = acc_out_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^tc_bus.tcRdAddr;
    assign tc_bus.accOut  = '0;
`endif
endmodule

// File: tb/tb_tc_accumulator_bank.sv
// Self-checking bench for tc_accumulator_bank: directed timer/counter scenarios plus randomized traffic
// compared against a behavioural channel model; works with or without TC_ACC_READ_EN.
module tb_tc_accumulator_bank;
    localparam int N  = 12;
    localparam int W  = 8;
    localparam int A  = 4;
    localparam int TD = 4;
    localparam int SAT = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tc_accumulator_bank_if #(.TC_NUM(N), .PRESET_LEN(W), .ADDR_LEN(A)) tc_bus ();

    tc_accumulator_bank #(.TC_NUM(N), .PRESET_LEN(W), .ADDR_LEN(A), .TICK_DIV(TD)) dut (
        .clk    (clk),
        .reset  (reset),
        .tc_bus (tc_bus)
    );

    int pre [N];
    always_comb begin
        tc_bus.presetIn = '0;
        for (int n = 0; n < N; n++) tc_bus.presetIn[n*W +: W] = W'(pre[n]);
    end

    // Behavioural model state
    int         m_acc  [N];
    int         m_type [N];
    logic [N-1:0] m_done;
    logic [N-1:0] m_prev;
    int         m_ps;
    int         m_accout;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            m_acc[n]  = 0;
            m_type[n] = 0;
        end
        m_done   = '0;
        m_prev   = '0;
        m_ps     = 0;
        m_accout = 0;
    endtask

    // Apply one clock edge to the model from the current inputs, then advance the DUT.
    task automatic step();
        int nacc [N];
        int ntype [N];
        logic [N-1:0] ndone;
        bit tick, en, rise;
        int p, a, rd;
        tick = (m_ps == TD - 1);
        for (int n = 0; n < N; n++) begin
            en = tc_bus.tcEn[n];
            rise = en && !m_prev[n];
            a = m_acc[n];
            p = pre[n];
            ntype[n] = m_type[n];
            if ((tc_bus.tcRstEn || tc_bus.tcTypeWr) && int'(tc_bus.tcAddr) == n) begin
                nacc[n] = 0;
                ndone[n] = 1'b0;
                if (tc_bus.tcTypeWr) ntype[n] = int'(tc_bus.tcTypeIn);
            end else begin
                case (m_type[n])
                    0: begin
                        nacc[n] = !en ? 0 : ((tick && a < p) ? a + 1 : a);
                        ndone[n] = en && (nacc[n] >= p);
                    end
                    1: begin
                        nacc[n] = en ? 0 : ((tick && a < p) ? a + 1 : a);
                        ndone[n] = en || (nacc[n] < p);
                    end
                    2: begin
                        nacc[n] = (rise && a < SAT) ? a + 1 : a;
                        ndone[n] = (nacc[n] >= p);
                    end
                    default: begin
                        nacc[n] = (en && tick && a < p) ? a + 1 : a;
                        ndone[n] = (nacc[n] >= p);
                    end
                endcase
            end
        end
        rd = int'(tc_bus.tcRdAddr);
`ifdef TC_ACC_READ_EN
        m_accout = (rd < N) ? m_acc[rd] : 0;
`else
        m_accout = 0;
`endif
        for (int n = 0; n < N; n++) begin
            m_acc[n]  = nacc[n];
            m_type[n] = ntype[n];
        end
        m_done = ndone;
        m_prev = tc_bus.tcEn;
        m_ps   = (m_ps + 1) % TD;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic cmd(input int addr, input bit rst_en, input bit type_wr, input int typ);
        tc_bus.tcAddr   = A'(addr);
        tc_bus.tcRstEn  = rst_en;
        tc_bus.tcTypeWr = type_wr;
        tc_bus.tcTypeIn = 2'(typ);
        step();
        tc_bus.tcRstEn  = 1'b0;
        tc_bus.tcTypeWr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tc_bus.tcEn = '0; tc_bus.tcAddr = '0; tc_bus.tcRstEn = 1'b0;
        tc_bus.tcTypeWr = 1'b0; tc_bus.tcTypeIn = 2'b00; tc_bus.tcRdAddr = '0;
        for (int n = 0; n < N; n++) pre[n] = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tc_bus.tcDone !== '0) begin
            errors++; $display("FAIL reset_done: got %h expected 0", tc_bus.tcDone);
        end
        checks++;
        if (tc_bus.accOut !== '0) begin
            errors++; $display("FAIL reset_accout: got %0d expected 0", tc_bus.accOut);
        end
        reset = 1'b0;
        model_reset();
        $display("test_reset: done=%h accOut=%0d", tc_bus.tcDone, tc_bus.accOut);
    endtask

    task automatic test_ton();
        pre[0] = 3;
        tc_bus.tcRdAddr = '0;
        tc_bus.tcEn[0] = 1'b1;
        run(3 * TD - 1);
        checks++;
        if (tc_bus.tcDone[0] !== 1'b0) begin
            errors++; $display("FAIL ton_before_third_tick: got %b expected 0", tc_bus.tcDone[0]);
        end
        step();
        checks++;
        if (tc_bus.tcDone[0] !== 1'b1) begin
            errors++; $display("FAIL ton_third_tick: got %b expected 1", tc_bus.tcDone[0]);
        end
        step();
`ifdef TC_ACC_READ_EN
        checks++;
        if (tc_bus.accOut !== 8'd3) begin
            errors++; $display("FAIL ton_acc_read: got %0d expected 3", tc_bus.accOut);
        end
`endif
        tc_bus.tcEn[0] = 1'b0;
        step();
        checks++;
        if (tc_bus.tcDone[0] !== 1'b0) begin
            errors++; $display("FAIL ton_disable: got %b expected 0", tc_bus.tcDone[0]);
        end
        $display("test_ton: done0=%b", tc_bus.tcDone[0]);
    endtask

    task automatic test_tof();
        int waited;
        pre[1] = 2;
        cmd(1, 1'b0, 1'b1, 1);
        tc_bus.tcEn[1] = 1'b1;
        run(3);
        checks++;
        if (tc_bus.tcDone[1] !== 1'b1) begin
            errors++; $display("FAIL tof_enabled: got %b expected 1", tc_bus.tcDone[1]);
        end
        tc_bus.tcEn[1] = 1'b0;
        waited = 0;
        while (tc_bus.tcDone[1] === 1'b1 && waited < 4 * TD) begin
            step();
            waited++;
        end
        checks++;
        if (tc_bus.tcDone[1] !== 1'b0 || waited < TD + 1) begin
            errors++; $display("FAIL tof_falls: got done=%b after %0d edges expected 0 after >=%0d", tc_bus.tcDone[1], waited, TD + 1);
        end
        tc_bus.tcEn[1] = 1'b1;
        step();
        checks++;
        if (tc_bus.tcDone[1] !== 1'b1) begin
            errors++; $display("FAIL tof_reenable: got %b expected 1", tc_bus.tcDone[1]);
        end
        $display("test_tof: fall after %0d edges", waited);
    endtask

    task automatic test_ctu();
        pre[2] = 5;
        tc_bus.tcRdAddr = A'(2);
        cmd(2, 1'b0, 1'b1, 2);
        for (int p = 1; p <= 5; p++) begin
            tc_bus.tcEn[2] = 1'b1; run(3);
            tc_bus.tcEn[2] = 1'b0; run(2);
            if (p == 4) begin
                checks++;
                if (tc_bus.tcDone[2] !== 1'b0) begin
                    errors++; $display("FAIL ctu_four_pulses: got %b expected 0", tc_bus.tcDone[2]);
                end
            end
        end
        checks++;
        if (tc_bus.tcDone[2] !== 1'b1) begin
            errors++; $display("FAIL ctu_five_pulses: got %b expected 1", tc_bus.tcDone[2]);
        end
`ifdef TC_ACC_READ_EN
        checks++;
        if (tc_bus.accOut !== 8'd5) begin
            errors++; $display("FAIL ctu_acc_read: got %0d expected 5", tc_bus.accOut);
        end
`endif
        pre[2] = SAT;
        cmd(2, 1'b1, 1'b0, 0);
        for (int p = 1; p <= 300; p++) begin
            tc_bus.tcEn[2] = 1'b1; step();
            tc_bus.tcEn[2] = 1'b0; step();
            if (p == 254) begin
                checks++;
                if (tc_bus.tcDone[2] !== 1'b0) begin
                    errors++; $display("FAIL ctu_254_pulses: got %b expected 0", tc_bus.tcDone[2]);
                end
            end
        end
        checks++;
        if (tc_bus.tcDone[2] !== 1'b1) begin
            errors++; $display("FAIL ctu_saturated_done: got %b expected 1", tc_bus.tcDone[2]);
        end
`ifdef TC_ACC_READ_EN
        checks++;
        if (tc_bus.accOut !== 8'd255) begin
            errors++; $display("FAIL ctu_saturate: got %0d expected 255", tc_bus.accOut);
        end
`endif
        $display("test_ctu: done2=%b accOut=%0d", tc_bus.tcDone[2], tc_bus.accOut);
    endtask

    task automatic test_rto();
        pre[3] = 4;
        tc_bus.tcRdAddr = A'(3);
        cmd(3, 1'b0, 1'b1, 3);
        tc_bus.tcEn[3] = 1'b1; run(2 * TD);
        tc_bus.tcEn[3] = 1'b0; run(10 * TD);
        checks++;
        if (tc_bus.tcDone[3] !== 1'b0) begin
            errors++; $display("FAIL rto_hold: got %b expected 0", tc_bus.tcDone[3]);
        end
`ifdef TC_ACC_READ_EN
        checks++;
        if (tc_bus.accOut !== 8'd2) begin
            errors++; $display("FAIL rto_hold_acc: got %0d expected 2", tc_bus.accOut);
        end
`endif
        tc_bus.tcEn[3] = 1'b1; run(2 * TD);
        checks++;
        if (tc_bus.tcDone[3] !== 1'b1) begin
            errors++; $display("FAIL rto_done: got %b expected 1", tc_bus.tcDone[3]);
        end
        tc_bus.tcEn[3] = 1'b0; run(5);
        checks++;
        if (tc_bus.tcDone[3] !== 1'b1) begin
            errors++; $display("FAIL rto_retain: got %b expected 1", tc_bus.tcDone[3]);
        end
        cmd(3, 1'b1, 1'b0, 0);
        checks++;
        if (tc_bus.tcDone[3] !== 1'b0) begin
            errors++; $display("FAIL rto_clear: got %b expected 0", tc_bus.tcDone[3]);
        end
        $display("test_rto: done3=%b", tc_bus.tcDone[3]);
    endtask

    task automatic test_type_change();
        pre[4] = 50;
        tc_bus.tcEn[4] = 1'b1;
        run(3 * TD);
        cmd(4, 1'b0, 1'b1, 2);
        checks++;
        if (tc_bus.tcDone[4] !== 1'b0) begin
            errors++; $display("FAIL type_wr_clear: got %b expected 0", tc_bus.tcDone[4]);
        end
        pre[4] = 1;
        run(2 * TD);
        checks++;
        if (tc_bus.tcDone[4] !== 1'b0) begin
            errors++; $display("FAIL type_wr_ticks_ignored: got %b expected 0", tc_bus.tcDone[4]);
        end
        tc_bus.tcEn[4] = 1'b0; step();
        tc_bus.tcEn[4] = 1'b1; step();
        checks++;
        if (tc_bus.tcDone[4] !== 1'b1) begin
            errors++; $display("FAIL type_wr_rise_counts: got %b expected 1", tc_bus.tcDone[4]);
        end
        $display("test_type_change: done4=%b", tc_bus.tcDone[4]);
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(0, 9) < 3) tc_bus.tcEn[n] = ~tc_bus.tcEn[n];
                if ($urandom_range(0, 39) == 0) pre[n] = $urandom_range(0, 6);
            end
            r = $urandom_range(0, 99);
            tc_bus.tcAddr   = A'($urandom_range(0, 15));
            tc_bus.tcRstEn  = (r < 5) || (r >= 95);
            tc_bus.tcTypeWr = (r >= 90);
            tc_bus.tcTypeIn = 2'($urandom_range(0, 3));
            tc_bus.tcRdAddr = A'($urandom_range(0, 15));
            step();
            checks++;
            if (tc_bus.tcDone !== m_done) begin
                errors++; $display("FAIL random_done cycle %0d: got %h expected %h", c, tc_bus.tcDone, m_done);
            end
            checks++;
            if (int'(tc_bus.accOut) !== m_accout) begin
                errors++; $display("FAIL random_accout cycle %0d: got %0d expected %0d", c, tc_bus.accOut, m_accout);
            end
        end
        tc_bus.tcRstEn = 1'b0;
        tc_bus.tcTypeWr = 1'b0;
        $display("test_random: 600 cycles, done=%h", tc_bus.tcDone);
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < N; n++) begin
            pre[n] = 1;
            tc_bus.tcEn[n] = 1'b1;
        end
        tc_bus.tcRdAddr = '0;
        run(3 * TD);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (tc_bus.tcDone !== '0) begin
            errors++; $display("FAIL async_reset_done: got %h expected 0", tc_bus.tcDone);
        end
        checks++;
        if (tc_bus.accOut !== '0) begin
            errors++; $display("FAIL async_reset_accout: got %0d expected 0", tc_bus.accOut);
        end
        tc_bus.tcEn = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        checks++;
        if (tc_bus.accOut !== '0) begin
            errors++; $display("FAIL post_reset_read: got %0d expected 0", tc_bus.accOut);
        end
        checks++;
        if (tc_bus.tcDone !== m_done) begin
            errors++; $display("FAIL post_reset_done: got %h expected %h", tc_bus.tcDone, m_done);
        end
        $display("test_async_reset: done=%h accOut=%0d", tc_bus.tcDone, tc_bus.accOut);
    endtask

    initial begin
        test_reset();
        test_ton();
        test_tof();
        test_ctu();
        test_rto();
        test_type_change();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
